cache_data: RTL and testbench
=============================

// Module: cache_data
// PURPOSE
//  Direct-mapped, read-allocate/write-allocate data cache between a CPU load/store port and a
//  burst-read RAM controller (BurstRAM protocol). A miss fills one whole line with one RAM burst.
//  Writes update the cached line only; there is no write-back or write-through path in this version.
// PARAMETERS
//  LINE_IX_BITWIDTH          1   log2(number of lines)
//  ADDRESS_BITWIDTH          32  CPU byte-address width
//  DATA_BITWIDTH             32  CPU word width (4 bytes)
//  DATA_IX_IN_LINE_BITWIDTH  3   log2(words per line); 8 words = 32 B
//  RAM_DEPTH_BITWIDTH        4   RAM address width, in RAM_BURST_DATA_BITWIDTH words
//  RAM_BURST_DATA_BITWIDTH   64  RAM beat width
//  RAM_BURST_DATA_COUNT      4   beats per burst
//  Constraint: 2^DATA_IX_IN_LINE_BITWIDTH*DATA_BITWIDTH == RAM_BURST_DATA_BITWIDTH*RAM_BURST_DATA_COUNT
// PORTS
//  clk                 in   1       single clock; all state changes on rising edge
//  rst_n               in   1       reset, asynchronous, active-low
//  enable              in   1       one-cycle request strobe; sampled only when busy=0
//  address             in   32      byte address (word-aligned)
//  data_out            out  32      read data
//  data_out_ready      out  1       data_out valid for the last read request
//  data_in             in   32      write data
//  write_enable_bytes  in   4       byte-lane write mask; 0 = read request
//  busy                out  1       request in progress; new requests ignored
//  br_cmd              out  1       RAM command, 0 = read burst (always 0 here)
//  br_cmd_en           out  1       one-cycle command strobe
//  br_addr             out  RAM_DEPTH_BITWIDTH  burst start address (RAM-word units)
//  br_rd_data          in   64      burst beat
//  br_rd_data_valid    in   1       beat valid; RAM_BURST_DATA_COUNT consecutive beats per burst
//  br_busy             in   1       RAM cannot accept a command
// BEHAVIOUR
//  Address split: [1:0] byte, [4:2] word ix, [5] line ix, [31:6] tag; per line: valid, tag, data.
//  Reset (rst_n=0, async): all valid bits 0; busy=0; data_out_ready=0; data_out=0; br_cmd_en=0;
//   br_cmd=0; br_addr=0; stat_cache_hits=stat_cache_misses=0; state IDLE.
//  IDLE: on enable&!busy register address/data_in/mask, clear data_out_ready, busy=1 next cycle.
//  LOOKUP (1 cycle): hit = valid & tag match. Hit: stat_cache_hits++; read -> data_out=word,
//   data_out_ready=1, busy=0 same cycle; write -> merge masked bytes, busy=0. Return to IDLE.
//  Miss: stat_cache_misses++ (reads and writes alike); wait while br_busy; then one cycle
//   br_cmd=0, br_cmd_en=1, br_addr = address[RAM_DEPTH_BITWIDTH+2:3] with low
//   log2(RAM_BURST_DATA_COUNT) bits zeroed (i.e. line-aligned).
//  FILL: beat k (counted on br_rd_data_valid) -> words 2k (bits 31:0) and 2k+1 (bits 63:32).
//   Read miss: data_out/data_out_ready=1 as soon as the requested word is written (may precede
//   end of burst); busy stays 1 until last beat. After last beat: set valid, store tag.
//   Write miss: after fill, merge data_in bytes per write_enable_bytes into the word, busy=0.
//  Eviction: a miss overwrites the indexed line unconditionally; modified data is discarded.
//  data_out, data_out_ready hold until the next accepted enable; writes never set data_out_ready.
//  enable while busy=1 is ignored. rst_n low mid-burst aborts; remaining RAM beats are ignored
//   (fill counter reset, no line marked valid).
//  stat_cache_hits/stat_cache_misses: 32-bit internal counters, hierarchically readable.
// STRUCTURE
//  Package cache_data_pkg: state enum (IDLE, LOOKUP, WAIT_RAM, CMD, FILL, WRITE_MERGE),
//   address-field width localparams, BR_CMD_READ/BR_CMD_WRITE constants.
//  One sub-module: cache_line_store (line data array, per-word 4-bit byte-enable write port,
//   64-bit beat write port, one read port). Tags/valid bits and FSM in cache_data.
// TESTING (BurstRAM: 64-bit, 16 deep, latency 3, burst 4; word@byte 0=B7C6A980,
//   4=3F5A2E14, 8=AB4C3E6F, 16=D5B8A9C4, 32=2F5E3C7A, 68=0A1B2C3D)
//  1 Read 0 after reset -> misses=1, data_out=B7C6A980, one br_cmd_en with br_addr=0.
//  2 Reads 4, 8, 16 -> hits=1,2,3; data 3F5A2E14, AB4C3E6F, D5B8A9C4; no br_cmd_en.
//  3 Read 32 -> misses=2, br_addr=4, data 2F5E3C7A; line 0 still valid (hit on re-read of 0).
//  4 Read 68 -> misses=3, evicts line 0, br_addr=8, data 0A1B2C3D.
//  5 Write 0, data_in=12345678, mask=0010 -> misses=4; then read 0 -> B7C65680.
//  6 enable pulsed while busy -> ignored, counters unchanged; async rst_n mid-fill -> all reset.

Source files
------------

// File: rtl/cache_data_pkg.sv
// Shared types and default geometry for the direct-mapped data cache.
// Address fields, top down: tag | line index | word index | byte offset.
package cache_data_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    WAIT_RAM,
    CMD,
    FILL,
    WRITE_MERGE
  } state_t;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int BYTE_OFS_W  = 2;
  localparam int WORD_IX_W   = 3;
  localparam int LINE_IX_W   = 1;
  localparam int TAG_W       = ADDR_W - LINE_IX_W - WORD_IX_W - BYTE_OFS_W;
  localparam int RAM_DEPTH_W = 4;
  localparam int BEAT_W      = 64;
  localparam int BEAT_CNT    = 4;

  localparam logic BR_CMD_READ  = 1'b0;
  localparam logic BR_CMD_WRITE = 1'b1;

endpackage

// File: rtl/cache_line_store.sv
// Line data array: byte-enabled word write, whole-beat write, combinational word read.
// Single-cycle writes; no backpressure (callers never issue both writes in one cycle).
module cache_line_store #(
  parameter int LINE_IX_W = 1,
  parameter int WORD_IX_W = 3,
  parameter int DATA_W    = 32,
  parameter int BEAT_W    = 64
) (
  input  logic                           clk,
  input  logic [LINE_IX_W+WORD_IX_W-1:0] word_addr,
  input  logic [DATA_W/8-1:0]            word_be,
  input  logic [DATA_W-1:0]              word_dat,
  input  logic                           beat_we,
  input  logic [LINE_IX_W+WORD_IX_W-$clog2(BEAT_W/DATA_W)-1:0] beat_addr,
  input  logic [BEAT_W-1:0]              beat_dat,
  input  logic [LINE_IX_W+WORD_IX_W-1:0] rd_addr,
  output logic [DATA_W-1:0]              rd_dat
);

  localparam int WPB   = BEAT_W / DATA_W;
  localparam int WPB_W = $clog2(WPB);
  localparam int DEPTH = 2 ** (LINE_IX_W + WORD_IX_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Beat k of a line lands in words {k, 0..WPB-1}, low word first.
  always_ff @(posedge clk) begin
    if (beat_we) begin
      for (int w = 0; w < WPB; w++) begin
        mem[{beat_addr, w[WPB_W-1:0]}] <= beat_dat[w*DATA_W +: DATA_W];
      end
    end
    for (int b = 0; b < DATA_W / 8; b++) begin
      if (word_be[b]) mem[word_addr][b*8 +: 8] <= word_dat[b*8 +: 8];
    end
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/cache_data.sv
// Direct-mapped read/write-allocate data cache; hit answers one cycle after the request,
// miss fills the whole line with one RAM burst. busy blocks new requests until done.
module cache_data
  import cache_data_pkg::*;
#(
  parameter int LINE_IX_BITWIDTH         = LINE_IX_W,
  parameter int ADDRESS_BITWIDTH         = ADDR_W,
  parameter int DATA_BITWIDTH            = DATA_W,
  parameter int DATA_IX_IN_LINE_BITWIDTH = WORD_IX_W,
  parameter int RAM_DEPTH_BITWIDTH       = RAM_DEPTH_W,
  parameter int RAM_BURST_DATA_BITWIDTH  = BEAT_W,
  parameter int RAM_BURST_DATA_COUNT     = BEAT_CNT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [ADDRESS_BITWIDTH-1:0]   address,
  output logic [DATA_BITWIDTH-1:0]      data_out,
  output logic                          data_out_ready,
  input  logic [DATA_BITWIDTH-1:0]      data_in,
  input  logic [DATA_BITWIDTH/8-1:0]    write_enable_bytes,
  output logic                          busy,
  output logic                          br_cmd,
  output logic                          br_cmd_en,
  output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
  input  logic [RAM_BURST_DATA_BITWIDTH-1:0] br_rd_data,
  input  logic                          br_rd_data_valid,
  input  logic                          br_busy
);

  localparam int BYTE_OFS  = $clog2(DATA_BITWIDTH / 8);
  localparam int LINE_LSB  = BYTE_OFS + DATA_IX_IN_LINE_BITWIDTH;
  localparam int TAG_LSB   = LINE_LSB + LINE_IX_BITWIDTH;
  localparam int TAG_BW    = ADDRESS_BITWIDTH - TAG_LSB;
  localparam int NUM_LINES = 2 ** LINE_IX_BITWIDTH;
  localparam int BEAT_IX_W = $clog2(RAM_BURST_DATA_COUNT);
  localparam int WPB_W     = $clog2(RAM_BURST_DATA_BITWIDTH / DATA_BITWIDTH);
  localparam int RAM_OFS   = $clog2(RAM_BURST_DATA_BITWIDTH / 8);

  state_t state_q, state_d;

  logic [ADDRESS_BITWIDTH-1:0]         req_addr;
  logic [DATA_BITWIDTH-1:0]            req_dat;
  logic [DATA_BITWIDTH/8-1:0]          req_mask;
  logic [BEAT_IX_W-1:0]                fill_cnt;
  logic [NUM_LINES-1:0]                valid_q;
  logic [TAG_BW-1:0]                   tag_q [NUM_LINES];
  logic [31:0]                         stat_cache_hits;
  logic [31:0]                         stat_cache_misses;

  logic [TAG_BW-1:0]                   req_tag;
  logic [LINE_IX_BITWIDTH-1:0]         req_line;
  logic [DATA_IX_IN_LINE_BITWIDTH-1:0] req_word;
  logic                                req_write;
  logic                                hit;
  logic                                last_beat;
  logic [DATA_BITWIDTH-1:0]            rd_dat;
  logic [DATA_BITWIDTH/8-1:0]          word_be;
  logic                                unused_byte_ofs;

  assign req_tag   = req_addr[ADDRESS_BITWIDTH-1:TAG_LSB];
  assign req_line  = req_addr[TAG_LSB-1:LINE_LSB];
  assign req_word  = req_addr[LINE_LSB-1:BYTE_OFS];
  assign req_write = |req_mask;
  assign hit       = valid_q[req_line] && (tag_q[req_line] == req_tag);
  assign last_beat = br_rd_data_valid && (fill_cnt == BEAT_IX_W'(RAM_BURST_DATA_COUNT - 1));
  assign unused_byte_ofs = ^req_addr[BYTE_OFS-1:0];

  assign busy      = (state_q != IDLE);
  assign br_cmd    = BR_CMD_READ;
  assign br_cmd_en = (state_q == CMD);

  // Hit writes and post-fill write merges share the byte-enable port.
  assign word_be = ((state_q == LOOKUP && hit) || state_q == WRITE_MERGE) ? req_mask : '0;

  cache_line_store #(
    .LINE_IX_W (LINE_IX_BITWIDTH),
    .WORD_IX_W (DATA_IX_IN_LINE_BITWIDTH),
    .DATA_W    (DATA_BITWIDTH),
    .BEAT_W    (RAM_BURST_DATA_BITWIDTH)
  ) u_store (
    .clk       (clk),
    .word_addr ({req_line, req_word}),
    .word_be   (word_be),
    .word_dat  (req_dat),
    .beat_we   (state_q == FILL && br_rd_data_valid),
    .beat_addr ({req_line, fill_cnt}),
    .beat_dat  (br_rd_data),
    .rd_addr   ({req_line, req_word}),
    .rd_dat    (rd_dat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (enable) state_d = LOOKUP;
      LOOKUP:      state_d = hit ? IDLE : WAIT_RAM;
      WAIT_RAM:    if (!br_busy) state_d = CMD;
      CMD:         state_d = FILL;
      FILL:        if (last_beat) state_d = req_write ? WRITE_MERGE : IDLE;
      WRITE_MERGE: state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_addr          <= '0;
      req_dat           <= '0;
      req_mask          <= '0;
      fill_cnt          <= '0;
      valid_q           <= '0;
      data_out          <= '0;
      data_out_ready    <= 1'b0;
      br_addr           <= '0;
      stat_cache_hits   <= '0;
      stat_cache_misses <= '0;
      for (int i = 0; i < NUM_LINES; i++) tag_q[i] <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (enable) begin
            req_addr       <= address;
            req_dat        <= data_in;
            req_mask       <= write_enable_bytes;
            data_out_ready <= 1'b0;
          end
        end
        LOOKUP: begin
          if (hit) begin
            stat_cache_hits <= stat_cache_hits + 32'd1;
            if (!req_write) begin
              data_out       <= rd_dat;
              data_out_ready <= 1'b1;
            end
          end else begin
            // The indexed line is victimised now; its old contents are simply dropped.
            stat_cache_misses <= stat_cache_misses + 32'd1;
            valid_q[req_line] <= 1'b0;
            fill_cnt          <= '0;
            br_addr <= {req_addr[RAM_DEPTH_BITWIDTH+RAM_OFS-1:RAM_OFS+BEAT_IX_W],
                        {BEAT_IX_W{1'b0}}};
          end
        end
        FILL: begin
          if (br_rd_data_valid) begin
            fill_cnt <= fill_cnt + 1'b1;
            // Forward the requested word straight from the beat, ahead of burst end.
            if (!req_write && fill_cnt == req_word[DATA_IX_IN_LINE_BITWIDTH-1:WPB_W]) begin
              data_out       <= br_rd_data[req_word[WPB_W-1:0]*DATA_BITWIDTH +: DATA_BITWIDTH];
              data_out_ready <= 1'b1;
            end
            if (last_beat) begin
              valid_q[req_line] <= 1'b1;
              tag_q[req_line]   <= req_tag;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_data.sv
// Bench for cache_data: BurstRAM responder, table of request vectors, scoreboard of read data.
// Hand sequences cover requests pulsed while busy and reset asserted in the middle of a fill.
module tb_cache_data;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [31:0] address;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic [31:0] data_in;
  logic [3:0]  write_enable_bytes;
  logic        busy;
  logic        br_cmd;
  logic        br_cmd_en;
  logic [3:0]  br_addr;
  logic [63:0] br_rd_data = '0;
  logic        br_rd_data_valid = 1'b0;
  logic        br_busy = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          cmd_cnt = 0;
  logic [3:0]  last_br_addr = '0;
  logic [31:0] sb_q [$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  mask;
    logic [31:0] rdat;
    int          hits;
    int          misses;
    int          cmds;
    logic [3:0]  braddr;
    bit          early;
  } vec_t;

  vec_t vecs [14];

  always #5 clk = ~clk;

  cache_data dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .enable             (enable),
    .address            (address),
    .data_out           (data_out),
    .data_out_ready     (data_out_ready),
    .data_in            (data_in),
    .write_enable_bytes (write_enable_bytes),
    .busy               (busy),
    .br_cmd             (br_cmd),
    .br_cmd_en          (br_cmd_en),
    .br_addr            (br_addr),
    .br_rd_data         (br_rd_data),
    .br_rd_data_valid   (br_rd_data_valid),
    .br_busy            (br_busy)
  );

  // BurstRAM: 16 x 64, first beat three cycles after the command, four back-to-back beats.
  logic [63:0] ram [16];
  int          ph = 0;
  logic [3:0]  ram_a = '0;

  always @(posedge clk) begin
    br_rd_data_valid <= 1'b0;
    if (ph == 0) begin
      if (br_cmd_en) begin
        ph      <= 1;
        ram_a   <= br_addr;
        br_busy <= 1'b1;
      end
    end else begin
      if (ph >= 3) begin
        br_rd_data_valid <= 1'b1;
        br_rd_data       <= ram[ram_a + 4'(ph - 3)];
      end
      if (ph == 6) begin
        ph      <= 0;
        br_busy <= 1'b0;
      end else begin
        ph <= ph + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (br_cmd_en) begin
      cmd_cnt++;
      last_br_addr = br_addr;
      check("br_cmd", 32'(br_cmd), 32'd0);
    end
  end

  task automatic check_reset(input string tag);
    check({tag, " busy"},           32'(busy), 32'd0);
    check({tag, " data_out_ready"}, 32'(data_out_ready), 32'd0);
    check({tag, " data_out"},       data_out, 32'd0);
    check({tag, " br_cmd_en"},      32'(br_cmd_en), 32'd0);
    check({tag, " br_cmd"},         32'(br_cmd), 32'd0);
    check({tag, " br_addr"},        32'(br_addr), 32'd0);
    check({tag, " hits"},           dut.stat_cache_hits, 32'd0);
    check({tag, " misses"},         dut.stat_cache_misses, 32'd0);
    check({tag, " valid"},          32'(dut.valid_q), 32'd0);
  endtask

  task automatic do_req(input string name, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] m, input logic [31:0] rd, input int eh, input int em,
                        input int ec, input logic [3:0] eba, input bit ee, input bit pulse);
    int          n;
    bit          early;
    int          c0;
    logic [31:0] exp_d;
    c0 = cmd_cnt;
    if (m == 4'h0) sb_q.push_back(rd);
    @(negedge clk);
    enable = 1'b1; address = a; data_in = wd; write_enable_bytes = m;
    n = 0;
    early = 1'b0;
    do begin
      @(negedge clk);
      if (pulse && n == 1) begin
        enable = 1'b1; address = 32'h4; data_in = 32'hFFFF_FFFF; write_enable_bytes = 4'hF;
      end else begin
        enable = 1'b0;
      end
      if (busy && data_out_ready) early = 1'b1;
      n++;
    end while (busy && n < 300);
    enable = 1'b0;
    check({name, " busy"}, 32'(busy), 32'd0);
    if (m == 4'h0) begin
      exp_d = sb_q.pop_front();
      check({name, " data_out"}, data_out, exp_d);
      check({name, " data_out_ready"}, 32'(data_out_ready), 32'd1);
      check({name, " early_ready"}, 32'(early), 32'(ee));
    end else begin
      check({name, " data_out_ready"}, 32'(data_out_ready), 32'd0);
    end
    check({name, " hits"}, dut.stat_cache_hits, 32'(eh));
    check({name, " misses"}, dut.stat_cache_misses, 32'(em));
    check({name, " br_cmd_en count"}, 32'(cmd_cnt - c0), 32'(ec));
    if (ec > 0) check({name, " br_addr"}, 32'(last_br_addr), 32'(eba));
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) begin
      ram[i] = {32'h1000_0000 + 32'(2 * i + 1), 32'h1000_0000 + 32'(2 * i)};
    end
    ram[0]         = {32'h3F5A_2E14, 32'hB7C6_A980};
    ram[1][31:0]   = 32'hAB4C_3E6F;
    ram[2][31:0]   = 32'hD5B8_A9C4;
    ram[4][31:0]   = 32'h2F5E_3C7A;
    ram[8][63:32]  = 32'h0A1B_2C3D;

    //          addr    wdat          mask  rdat          hit mis cmd braddr early
    vecs[0]  = '{32'd0,  32'h0,        4'h0, 32'hB7C6A980, 0, 1, 1, 4'd0, 1'b1};
    vecs[1]  = '{32'd4,  32'h0,        4'h0, 32'h3F5A2E14, 1, 1, 0, 4'd0, 1'b0};
    vecs[2]  = '{32'd8,  32'h0,        4'h0, 32'hAB4C3E6F, 2, 1, 0, 4'd0, 1'b0};
    vecs[3]  = '{32'd16, 32'h0,        4'h0, 32'hD5B8A9C4, 3, 1, 0, 4'd0, 1'b0};
    vecs[4]  = '{32'd32, 32'h0,        4'h0, 32'h2F5E3C7A, 3, 2, 1, 4'd4, 1'b1};
    vecs[5]  = '{32'd0,  32'h0,        4'h0, 32'hB7C6A980, 4, 2, 0, 4'd0, 1'b0};
    vecs[6]  = '{32'd68, 32'h0,        4'h0, 32'h0A1B2C3D, 4, 3, 1, 4'd8, 1'b1};
    vecs[7]  = '{32'd0,  32'h12345678, 4'h2, 32'h0,        4, 4, 1, 4'd0, 1'b0};
    vecs[8]  = '{32'd0,  32'h0,        4'h0, 32'hB7C65680, 5, 4, 0, 4'd0, 1'b0};
    vecs[9]  = '{32'd4,  32'hAABBCCDD, 4'h9, 32'h0,        6, 4, 0, 4'd0, 1'b0};
    vecs[10] = '{32'd4,  32'h0,        4'h0, 32'hAA5A2EDD, 7, 4, 0, 4'd0, 1'b0};
    vecs[11] = '{32'd60, 32'h0,        4'h0, 32'h1000000F, 8, 4, 0, 4'd0, 1'b0};
    vecs[12] = '{32'd92, 32'h0,        4'h0, 32'h10000017, 8, 5, 1, 4'd8, 1'b0};
    vecs[13] = '{32'd0,  32'h0,        4'h0, 32'hB7C6A980, 8, 6, 1, 4'd0, 1'b1};

    rst_n = 1'b0; enable = 1'b0; address = '0; data_in = '0; write_enable_bytes = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      do_req($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wdat, vecs[i].mask, vecs[i].rdat,
             vecs[i].hits, vecs[i].misses, vecs[i].cmds, vecs[i].braddr, vecs[i].early, 1'b0);
    end

    // A write pulsed into the middle of a read miss must leave no trace.
    do_req("busy_ignore", 32'd100, 32'h0, 4'h0, 32'h10000019, 8, 7, 1, 4'd12, 1'b1, 1'b1);
    do_req("after_ignore", 32'd4, 32'h0, 4'h0, 32'h3F5A2E14, 9, 7, 0, 4'd0, 1'b0, 1'b0);

    // Reset lands after the first beat of a fill; the rest of the burst must be ignored.
    @(negedge clk);
    enable = 1'b1; address = 32'd40; write_enable_bytes = 4'h0;
    @(negedge clk);
    enable = 1'b0;
    n = 0;
    while (!br_rd_data_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("midfill first beat", 32'(br_rd_data_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset("midfill reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_req("after_reset", 32'd40, 32'h0, 4'h0, 32'h1000000A, 0, 1, 1, 4'd4, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
